// File: rtl/dii_package.sv
// Shared debug-interconnect types: one flit carries valid, end-of-packet and 16 data bits.
package dii_package;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

endpackage

// File: rtl/osd_rr_select.sv
// Cyclic priority pick: first set request at or after start, wrapping modulo N.
// Purely combinational; no backpressure.
module osd_rr_select #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         vld,
   output logic [W-1:0] idx
);

   logic [W:0] k;

   always_comb begin
      vld = 1'b0;
      idx = '0;
      k   = '0;
      for (int i = 0; i < N; i++) begin
         k = {1'b0, start} + (W+1)'(i);
         if (k >= (W+1)'(N)) k = k - (W+1)'(N);
         if (!vld && req[k[W-1:0]]) begin
            vld = 1'b1;
            idx = k[W-1:0];
         end
      end
   end

endmodule

// File: rtl/osd_diag_packet_arbiter.sv
// Round-robin packet arbiter: N debug sources onto one registered output, 1-cycle latency.
// Grant holds for a whole packet; over-length packets are cut at MAX_PKT_LEN and the tail drained.
module osd_diag_packet_arbiter
   import dii_package::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int MAX_PKT_LEN = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  dii_flit                    in_flit [NUM_SRC],
   output logic [NUM_SRC-1:0]         in_ready,
   output dii_flit                    out_flit,
   input  logic                       out_ready,
   output logic                       trunc_pulse,
   output logic [$clog2(NUM_SRC)-1:0] trunc_src
);

   localparam int SW = $clog2(NUM_SRC);
   localparam int CW = $clog2(MAX_PKT_LEN + 1);

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   grant, last_grant, start, sel_idx;
   logic            sel_vld;
   logic [NUM_SRC-1:0] req;
   logic [CW-1:0]   flit_cnt;
   dii_flit         cur;
   logic            acc, at_limit, pass_rdy;

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) req[i] = in_flit[i].valid;
   end

   assign start    = (last_grant == SW'(NUM_SRC - 1)) ? '0 : last_grant + 1'b1;
   assign cur      = in_flit[grant];
   assign at_limit = (flit_cnt == CW'(MAX_PKT_LEN - 1));
   assign pass_rdy = !out_flit.valid || out_ready;

   osd_rr_select #(.N(NUM_SRC), .W(SW)) u_rr (
      .req   (req),
      .start (start),
      .vld   (sel_vld),
      .idx   (sel_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = '0;
      acc       = 1'b0;
      case (state)
         IDLE: if (sel_vld) state_nxt = PASS;
         PASS: begin
            in_ready[grant] = pass_rdy;
            acc = cur.valid && pass_rdy;
            if (acc) begin
               if (cur.last)     state_nxt = IDLE;
               else if (at_limit) state_nxt = DROP;
            end
         end
         DROP: begin
            in_ready[grant] = 1'b1;
            acc = cur.valid;
            if (acc && cur.last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant       <= '0;
         last_grant  <= SW'(NUM_SRC - 1);
         flit_cnt    <= '0;
         out_flit    <= '0;
         trunc_pulse <= 1'b0;
         trunc_src   <= '0;
      end else begin
         trunc_pulse <= 1'b0;
         if (out_ready) out_flit.valid <= 1'b0;
         case (state)
            IDLE: if (sel_vld) begin
               grant      <= sel_idx;
               last_grant <= sel_idx;
               flit_cnt   <= '0;
            end
            PASS: if (acc) begin
               // the flit hitting the length limit is forwarded as the packet end
               out_flit <= '{valid: 1'b1, last: cur.last || at_limit, data: cur.data};
               flit_cnt <= flit_cnt + 1'b1;
               if (!cur.last && at_limit) begin
                  trunc_pulse <= 1'b1;
                  trunc_src   <= grant;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_osd_diag_packet_arbiter.sv
// Bench for osd_diag_packet_arbiter: directed phases plus random packets against a packet-level model.
module tb_osd_diag_packet_arbiter;
   import dii_package::*;

   localparam int NS   = 4;
   localparam int MAXL = 8;

   logic          clk = 1'b0;
   logic          rst;
   dii_flit       in_flit [NS];
   logic [NS-1:0] in_ready;
   dii_flit       out_flit;
   logic          out_ready;
   logic          trunc_pulse;
   logic [1:0]    trunc_src;

   int tests = 0;
   int failed = 0;

   logic [16:0] sbuf [NS][512];
   int          shead [NS];
   int          stail [NS];
   logic [16:0] expq [$];
   int          trq [$];
   int          model_last;
   bit          chk_out, chk_no13, chk_cycle, rand_rdy, prev_hold;
   int          stall_lo, stall_hi, nout;
   dii_flit     prev_out;

   osd_diag_packet_arbiter #(.NUM_SRC(NS), .MAX_PKT_LEN(MAXL)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_flit     (in_flit),
      .in_ready    (in_ready),
      .out_flit    (out_flit),
      .out_ready   (out_ready),
      .trunc_pulse (trunc_pulse),
      .trunc_src   (trunc_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < NS; i++) begin
         shead[i] = 0;
         stail[i] = 0;
      end
   endtask

   task automatic push_pkt(input int s, input int len);
      for (int j = 0; j < len; j++) begin
         sbuf[s][stail[s]] = {(j == len - 1), 4'(s), 4'(j), 8'($urandom)};
         stail[s]++;
      end
   endtask

   // Packet-level model: sources stay valid back to back, so packets leave in
   // round-robin order over the sources that still hold packets.
   task automatic plan();
      int cur [NS];
      int p, s, c, n;
      logic [16:0] f;
      for (int i = 0; i < NS; i++) cur[i] = shead[i];
      p = (model_last + 1) % NS;
      forever begin
         s = -1;
         for (int k = 0; k < NS; k++) begin
            c = (p + k) % NS;
            if (s < 0 && cur[c] < stail[c]) s = c;
         end
         if (s < 0) break;
         n = 0;
         do begin
            f = sbuf[s][cur[s]];
            cur[s]++;
            n++;
            if (n < MAXL) expq.push_back(f);
            else if (n == MAXL) expq.push_back({1'b1, f[15:0]});
         end while (!f[16]);
         if (n > MAXL) trq.push_back(s);
         model_last = s;
         p = (s + 1) % NS;
      end
   endtask

   task automatic step(input int cyc);
      logic [16:0] f;
      bit stalled;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (shead[i] < stail[i]) begin
            f = sbuf[i][shead[i]];
            in_flit[i] = '{valid: 1'b1, last: f[16], data: f[15:0]};
         end else begin
            in_flit[i] = '0;
         end
      end
      stalled = (cyc >= stall_lo && cyc < stall_hi);
      if (stalled)       out_ready = 1'b0;
      else if (rand_rdy) out_ready = ($urandom_range(3) != 0);
      else               out_ready = 1'b1;
      #1;
      chk("onehot_rdy", 32'($onehot0(in_ready)), 1);
      if (prev_hold) chk("hold_stable", out_flit, prev_out);
      if (stalled) chk("stall_rdy", in_ready, 0);
      if (chk_no13) chk("rdy_src1_src3", {in_ready[3], in_ready[1]}, 0);
      if (chk_out && out_flit.valid && out_ready) begin
         if (expq.size() == 0) chk("extra_flit", out_flit.valid, 0);
         else chk("out_flit", {out_flit.last, out_flit.data}, expq.pop_front());
         if (chk_cycle && nout < 3) chk("lat_cycle", cyc, 2 + nout);
         nout++;
      end
      if (trunc_pulse) begin
         if (trq.size() == 0) chk("extra_trunc", trunc_pulse, 0);
         else chk("trunc_src", trunc_src, trq.pop_front());
         chk("trunc_last", {out_flit.valid, out_flit.last}, 2'b11);
      end
      for (int i = 0; i < NS; i++)
         if (in_flit[i].valid && in_ready[i]) shead[i]++;
      prev_hold = out_flit.valid && !out_ready;
      prev_out  = out_flit;
   endtask

   task automatic run(input int limit);
      bit done;
      nout = 0;
      for (int c = 0; c < limit; c++) begin
         step(c);
         done = (expq.size() == 0) && !out_flit.valid;
         for (int i = 0; i < NS; i++) if (shead[i] != stail[i]) done = 0;
         if (done) break;
      end
      chk("phase_flits_left", expq.size(), 0);
      chk("phase_trunc_left", trq.size(), 0);
      chk("phase_out_idle", out_flit.valid, 0);
   endtask

   initial begin
      for (int i = 0; i < NS; i++) in_flit[i] = '0;
      out_ready = 1'b1;
      chk_out = 1; chk_no13 = 0; chk_cycle = 0; rand_rdy = 0; prev_hold = 0;
      stall_lo = -1; stall_hi = -1;
      clear_src();

      // reset state, with a source already requesting
      rst = 1'b0;
      in_flit[0] = '{valid: 1'b1, last: 1'b1, data: 16'h1234};
      #12;
      chk("rst_out_flit", out_flit, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_trunc", trunc_pulse, 0);
      in_flit[0] = '0;
      #11 rst = 1'b1;
      model_last = NS - 1;

      // sources 0 and 2 with 3-flit packets at once
      clear_src();
      push_pkt(0, 3);
      push_pkt(2, 3);
      plan();
      chk_no13 = 1; chk_cycle = 1;
      run(60);
      chk_no13 = 0; chk_cycle = 0;

      // asynchronous reset in the middle of a packet
      clear_src();
      push_pkt(3, 6);
      chk_out = 0;
      for (int c = 0; c < 4; c++) step(c);
      chk("pre_rst_valid", out_flit.valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out_flit", out_flit, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_trunc", trunc_pulse, 0);
      shead[3] = stail[3];
      for (int i = 0; i < NS; i++) in_flit[i] = '0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      model_last = NS - 1;
      chk_out = 1; prev_hold = 0;

      // every source with continuous single-flit packets
      clear_src();
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NS; s++) push_pkt(s, 1);
      plan();
      run(100);

      // 10-flit packet on source 1 is cut to 8
      clear_src();
      push_pkt(1, 10);
      plan();
      run(100);

      // 5-cycle downstream stall in the middle of a packet
      clear_src();
      push_pkt(0, 6);
      plan();
      stall_lo = 4; stall_hi = 9;
      run(100);
      stall_lo = -1; stall_hi = -1;

      // random packets, lengths across the truncation boundary, random backpressure
      clear_src();
      rand_rdy = 1;
      for (int n = 0; n < 40; n++) push_pkt($urandom_range(NS - 1), $urandom_range(1, 11));
      plan();
      run(4000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/osd_diag_packet_arbiter.md
OSD_DIAG_PACKET_ARBITER -- requirements
Module: osd_diag_packet_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of debug packet sources sharing one output; legal range 2..16.
REQ-002 Parameter MAX_PKT_LEN, default 8: maximum flits per forwarded packet, header included; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 in_flit  input  dii_flit[NUM_SRC]  per-source flit with valid, last and data[15:0].
REQ-006 in_ready  output  NUM_SRC  per-source accept; a flit transfers when in_flit[i].valid and in_ready[i] are both high.
REQ-007 out_flit  output  dii_flit  forwarded flit, driven from a register.
REQ-008 out_ready  input  1  downstream accept.
REQ-009 trunc_pulse  output  1  one-cycle pulse when a packet is truncated.
REQ-010 trunc_src  output  $clog2(NUM_SRC)  index of the truncated source; valid while trunc_pulse is high.

Function
REQ-011 FSM states: IDLE, PASS, DROP.
REQ-012 IDLE: search in_flit[i].valid cyclically, starting at index last_grant+1 and wrapping modulo NUM_SRC.
  - On the first hit: set grant, set last_grant to that index, clear flit_cnt, go to PASS.
  - No flit is accepted in IDLE.
REQ-013 PASS: in_ready[grant] = !out_flit.valid | out_ready; every other in_ready bit is 0.
REQ-014 A flit accepted in PASS loads the output register on the same edge.
  - out_flit.valid is high the next cycle: one cycle of latency.
  - data is unchanged.
REQ-015 Output register accept/empty rules:
  - Holds its content while out_flit.valid & !out_ready.
  - Clears valid on an out_ready cycle that loads no new flit.
  - Back-to-back flits sustain one flit per cycle.
REQ-016 flit_cnt increments on each accepted flit; its width is $clog2(MAX_PKT_LEN+1).
REQ-017 Accepted flit with last=1: go to IDLE.
REQ-018 Accepted flit with last=0 and flit_cnt==MAX_PKT_LEN-1:
  - Forward it with last forced to 1.
  - Pulse trunc_pulse with trunc_src=grant on the following cycle.
  - Go to DROP.
REQ-019 DROP: in_ready[grant]=1; accepted flits are discarded and never reach the output register. On an accepted flit with last=1, go to IDLE.
REQ-020 Flits arriving from a source while it is not granted are held by the source, never lost, because in_ready is 0.
REQ-021 A source is not re-granted until every other source with a valid flit has been granted once: round-robin fairness.
REQ-022 A single-flit packet (last=1 on the first flit) completes PASS in one accept and returns to IDLE.

Reset
REQ-023 While rst is low, regardless of clk:
  - State is IDLE and last_grant is NUM_SRC-1, so the first search starts at source 0.
  - grant, flit_cnt, out_flit.valid, out_flit.last, in_ready and trunc_pulse are 0; out_flit.data is 0.
REQ-024 Reset asserted mid-packet aborts the packet without emitting last. The FSM restarts in IDLE when rst is released.

Structure
REQ-025 dii_flit is taken from dii_package; no new typedef is introduced.
REQ-026 The state enum is local to the module.
REQ-027 The cyclic priority search is a sub-module, osd_rr_select.
  - Inputs: request vector and start index.
  - Outputs: valid and index.

Verification
REQ-028 Sources 0 and 2 each present a 3-flit packet at once with out_ready=1:
  - Source 0's flits appear on cycles 2..4 with last on the third flit.
  - Source 2's packet follows.
  - Source 1 and source 3 in_ready stay 0.
REQ-029 All 4 sources hold continuous valid single-flit packets: grant order is 0,1,2,3,0,1 and no source is skipped.
REQ-030 Source 1 sends a 10-flit packet with MAX_PKT_LEN=8:
  - 8 flits are output, the 8th with last=1.
  - trunc_pulse=1 and trunc_src=1 for exactly one cycle.
  - Flits 9 and 10 are consumed and not output.
REQ-031 out_ready held low for 5 cycles mid-packet:
  - out_flit stays stable with data unchanged.
  - in_ready[grant] stays 0.
  - No flit is duplicated or lost after out_ready returns.
REQ-032 rst driven low asynchronously mid-packet: out_flit.valid and all in_ready go to 0 before the next clk edge. After release, arbitration restarts at source 0.
